// File: rtl/input_conditioner.sv
// Synchronizes and debounces 2 active-low keys and 10 switches, with press/release/change pulses.
// Latency: 2 sync + DEBOUNCE_CYCLES + 1 output register cycles per clean step; no backpressure (free-running).
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [1:0] key_n_in,
  input  logic [9:0] sw_in,
  output logic [1:0] button_export,
  output logic [9:0] switch_export,
  output logic [1:0] btn_press,
  output logic [1:0] btn_release,
  output logic [9:0] sw_change
);

  localparam int N = 12;
  // Bits [1:0] are the active-low keys (idle high), bits [11:2] the switches (idle low).
  localparam logic [N-1:0]     IDLE_VAL = {10'h000, 2'b11};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} state_t;

  logic [1:0]       rst_sync;
  logic             run;
  logic [N-1:0]     raw;
  logic [N-1:0]     meta;
  logic [N-1:0]     synced;
  logic [N-1:0]     stable_q;
  logic [N-1:0]     stable_d;
  logic [N-1:0]     out_q;
  state_t           state_q [N];
  state_t           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];
  logic [1:0]       press_q;
  logic [1:0]       release_q;
  logic [9:0]       change_q;

  assign raw = {sw_in, key_n_in};
  assign run = rst_sync[1];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rst_sync <= 2'b00;
      meta     <= IDLE_VAL;
      synced   <= IDLE_VAL;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      meta     <= raw;
      synced   <= meta;
    end
  end

  // Debouncers stay frozen until the internal reset release has propagated.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (run) begin
        unique case (state_q[i])
          STABLE: begin
            if (synced[i] != stable_q[i]) begin
              state_d[i] = PENDING;
              cnt_d[i]   = CNT_W'(1);
            end else begin
              cnt_d[i] = '0;
            end
          end
          PENDING: begin
            if (synced[i] == stable_q[i]) begin
              state_d[i] = STABLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              stable_d[i] = synced[i];
              state_d[i]  = STABLE;
              cnt_d[i]    = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_q <= IDLE_VAL;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Events compare the stable value with the previous export, so they line up with the export change.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q     <= IDLE_VAL;
      press_q   <= 2'b00;
      release_q <= 2'b00;
      change_q  <= 10'h000;
    end else begin
      out_q     <= stable_q;
      press_q   <= out_q[1:0] & ~stable_q[1:0];
      release_q <= ~out_q[1:0] & stable_q[1:0];
      change_q  <= out_q[11:2] ^ stable_q[11:2];
    end
  end

  assign button_export = out_q[1:0];
  assign switch_export = out_q[11:2];
  assign btn_press     = press_q;
  assign btn_release   = release_q;
  assign sw_change     = change_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4.
// A clean step driven at negedge K must show on the outputs at the negedge following edge K+7.
module tb_input_conditioner;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [1:0] key_n_in;
  logic [9:0] sw_in;
  logic [1:0] button_export;
  logic [9:0] switch_export;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [9:0] sw_change;

  input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .key_n_in      (key_n_in),
    .sw_in         (sw_in),
    .button_export (button_export),
    .switch_export (switch_export),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .sw_change     (sw_change)
  );

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [9:0] chg;
    logic [1:0] btn;
    logic [9:0] sw;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  localparam int STEP_LAT = 7;

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dly, input logic [1:0] press, input logic [1:0] rel,
                      input logic [9:0] chg, input logic [1:0] btn, input logic [9:0] sw);
    exp_t e;
    e.cyc = cyc + dly; e.press = press; e.rel = rel; e.chg = chg; e.btn = btn; e.sw = sw;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic check_quiet(input string name, input logic [1:0] btn, input logic [9:0] sw);
    check({name, "_btn"}, int'(button_export), int'(btn));
    check({name, "_sw"}, int'(switch_export), int'(sw));
    check({name, "_pulses"}, int'({btn_press, btn_release, sw_change}), 0);
  endtask

  // Monitor: every event pulse must match the head of the scoreboard, on the predicted cycle.
  always @(negedge clk_clk) begin
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      tests++;
      fails++;
      $display("FAIL missed_event: nothing seen by cycle %0d, expected at cycle %0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if ((|btn_press) || (|btn_release) || (|sw_change)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: press=%b release=%b change=%h at cycle %0d, expected none",
                 btn_press, btn_release, sw_change, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("btn_press", int'(btn_press), int'(e.press));
        check("btn_release", int'(btn_release), int'(e.rel));
        check("sw_change", int'(sw_change), int'(e.chg));
        check("button_export", int'(button_export), int'(e.btn));
        check("switch_export", int'(switch_export), int'(e.sw));
      end
    end
  end

  initial begin
    reset_reset_n = 1'b0;
    key_n_in      = 2'b11;
    sw_in         = 10'h000;
    #23;
    check_quiet("reset", 2'b11, 10'h000);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // Idle for 100 cycles: the monitor flags any pulse.
    wait_cyc(100);
    check_quiet("idle", 2'b11, 10'h000);

    // key 0 press and release.
    key_n_in = 2'b10;
    push(STEP_LAT, 2'b01, 2'b00, 10'h000, 2'b10, 10'h000);
    wait_cyc(12);
    key_n_in = 2'b11;
    push(STEP_LAT, 2'b00, 2'b01, 10'h000, 2'b11, 10'h000);
    wait_cyc(12);

    // sw 3 glitch of 3 cycles is swallowed.
    sw_in = 10'h008;
    wait_cyc(3);
    sw_in = 10'h000;
    wait_cyc(12);
    check_quiet("glitch", 2'b11, 10'h000);

    // sw 3 high 2, low 1, then held: count restarts from the final rise.
    sw_in = 10'h008;
    wait_cyc(2);
    sw_in = 10'h000;
    wait_cyc(1);
    sw_in = 10'h008;
    push(STEP_LAT, 2'b00, 2'b00, 10'h008, 2'b11, 10'h008);
    wait_cyc(12);
    sw_in = 10'h000;
    push(STEP_LAT, 2'b00, 2'b00, 10'h008, 2'b11, 10'h000);
    wait_cyc(12);

    // All 12 bits at once, then all back.
    sw_in    = 10'h3FF;
    key_n_in = 2'b00;
    push(STEP_LAT, 2'b11, 2'b00, 10'h3FF, 2'b00, 10'h3FF);
    wait_cyc(12);
    sw_in    = 10'h000;
    key_n_in = 2'b11;
    push(STEP_LAT, 2'b00, 2'b11, 10'h3FF, 2'b11, 10'h000);
    wait_cyc(12);

    // key 0 held pressed, then key 1 pressed; reset lands 2 cycles into key 1 PENDING.
    key_n_in = 2'b10;
    push(STEP_LAT, 2'b01, 2'b00, 10'h000, 2'b10, 10'h000);
    wait_cyc(12);
    check_quiet("key0_held", 2'b10, 10'h000);
    key_n_in = 2'b00;
    wait_cyc(4);
    reset_reset_n = 1'b0;
    #1;
    check_quiet("mid_pending_reset", 2'b11, 10'h000);
    sw_in = 10'h201;
    wait_cyc(3);
    check_quiet("in_reset", 2'b11, 10'h000);
    // Held keys and high switches at release go through a full fresh debounce.
    reset_reset_n = 1'b1;
    push(STEP_LAT, 2'b11, 2'b00, 10'h201, 2'b00, 10'h201);
    wait_cyc(12);
    key_n_in = 2'b11;
    sw_in    = 10'h000;
    push(STEP_LAT, 2'b00, 2'b11, 10'h201, 2'b11, 10'h000);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk_clk);
    wait_cyc(5);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d events outstanding, expected 0", sb.size());
    end
    check_quiet("final", 2'b11, 10'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
